dram_wr: RTL and testbench

Store path of the hxd32 data-memory interface, and the write-side counterpart of load formatting in writeback. It accepts store requests from the execute stage, holds them in a small in-order store buffer, and turns each one into one or two word-aligned write beats with byte enables. It handles any byte offset, including halfwords and words that cross a word boundary. It sits between EX and the DRAM port and frees the pipeline from waiting on memory-side stalls.

---
 rtl/dram_wr.sv | 156 +++++++++++++++
 tb/tb_dram_wr.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_wr.sv
// Store path of the hxd32 data-memory interface: an in-order store buffer that splits each
// byte/halfword/word store into one or two word-aligned write beats with byte enables.
module dram_wr #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [2:0]      dram_wr_sel_i,
    input  logic [XLEN-1:0] dram_wr_addr_i,
    input  logic [XLEN-1:0] dram_wr_data_i,
    output logic            mem_wr_en_o,
    output logic [XLEN-1:0] mem_wr_addr_o,
    output logic [3:0]      mem_wr_byteen_o,
    output logic [XLEN-1:0] mem_wr_data_o,
    input  logic            mem_wr_ready_i,
    output logic            busy_o
);

    // Store-size encodings of ram_op_enum.
    localparam logic [2:0] DRAM_WR_B = 3'd1;
    localparam logic [2:0] DRAM_WR_H = 3'd2;
    localparam logic [2:0] DRAM_WR_W = 3'd3;

    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned PtrW = AW + 1;

    typedef enum logic [1:0] {StIdle, StBeat0, StBeat1} state_e;

    state_e state_q, state_d;

    logic [2:0]      sel_q  [DEPTH];
    logic [XLEN-1:0] addr_q [DEPTH];
    logic [XLEN-1:0] data_q [DEPTH];

    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q, count;
    logic            empty, full, sel_ok, push, pop, last_entry;

    assign empty      = (wr_ptr_q == rd_ptr_q);
    assign full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count      = wr_ptr_q - rd_ptr_q;
    assign last_entry = (count == PtrW'(1));

    assign sel_ok = (dram_wr_sel_i == DRAM_WR_B) || (dram_wr_sel_i == DRAM_WR_H) ||
                    (dram_wr_sel_i == DRAM_WR_W);
    // Unknown sizes complete the handshake but never reach the buffer.
    assign push   = req_valid_i && !full && sel_ok;

    assign req_ready_o = !full;
    assign busy_o      = (state_q != StIdle) || !empty;

    always_ff @(posedge clk_i) begin
        if (push) begin
            sel_q[wr_ptr_q[AW-1:0]]  <= dram_wr_sel_i;
            addr_q[wr_ptr_q[AW-1:0]] <= dram_wr_addr_i;
            data_q[wr_ptr_q[AW-1:0]] <= dram_wr_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            state_q  <= StIdle;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            state_q <= state_d;
        end
    end

    // Lane formatting of the head entry.
    logic [2:0]      head_sel;
    logic [XLEN-1:0] head_addr, head_data, data_sized;
    logic [1:0]      off;
    logic [3:0]      base_mask;
    logic [7:0]      mask;
    logic [63:0]     raw;
    logic            need_beat1;
    logic [XLEN-1:0] beat0_addr, beat1_addr;

    assign head_sel  = sel_q[rd_ptr_q[AW-1:0]];
    assign head_addr = addr_q[rd_ptr_q[AW-1:0]];
    assign head_data = data_q[rd_ptr_q[AW-1:0]];
    assign off       = head_addr[1:0];

    always_comb begin
        base_mask  = 4'b0000;
        data_sized = '0;
        case (head_sel)
            DRAM_WR_B: begin
                base_mask  = 4'b0001;
                data_sized = {24'b0, head_data[7:0]};
            end
            DRAM_WR_H: begin
                base_mask  = 4'b0011;
                data_sized = {16'b0, head_data[15:0]};
            end
            DRAM_WR_W: begin
                base_mask  = 4'b1111;
                data_sized = head_data;
            end
            default: ;
        endcase
    end

    assign mask       = {4'b0000, base_mask} << off;
    assign raw        = {32'b0, data_sized} << {off, 3'b000};
    assign need_beat1 = |mask[7:4];
    assign beat0_addr = {head_addr[XLEN-1:2], 2'b00};
    assign beat1_addr = beat0_addr + XLEN'(4);

    always_comb begin
        state_d         = state_q;
        pop             = 1'b0;
        mem_wr_en_o     = 1'b0;
        mem_wr_addr_o   = '0;
        mem_wr_byteen_o = 4'b0000;
        mem_wr_data_o   = '0;
        unique case (state_q)
            StIdle: begin
                // Buffer is always empty here, so a push makes it non-empty next cycle.
                if (push) state_d = StBeat0;
            end
            StBeat0: begin
                mem_wr_en_o     = 1'b1;
                mem_wr_addr_o   = beat0_addr;
                mem_wr_byteen_o = mask[3:0];
                mem_wr_data_o   = raw[31:0];
                if (mem_wr_ready_i) begin
                    if (need_beat1) begin
                        state_d = StBeat1;
                    end else begin
                        pop     = 1'b1;
                        state_d = (last_entry && !push) ? StIdle : StBeat0;
                    end
                end
            end
            StBeat1: begin
                mem_wr_en_o     = 1'b1;
                mem_wr_addr_o   = beat1_addr;
                mem_wr_byteen_o = mask[7:4];
                mem_wr_data_o   = raw[63:32];
                if (mem_wr_ready_i) begin
                    pop     = 1'b1;
                    state_d = (last_entry && !push) ? StIdle : StBeat0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_dram_wr.sv
// Directed testbench for dram_wr: beat formatting, stalls, buffer full and async reset.
module tb_dram_wr;

    localparam logic [2:0] SB = 3'd1;
    localparam logic [2:0] SH = 3'd2;
    localparam logic [2:0] SW = 3'd3;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [2:0]  dram_wr_sel_i;
    logic [31:0] dram_wr_addr_i;
    logic [31:0] dram_wr_data_i;
    logic        mem_wr_en_o;
    logic [31:0] mem_wr_addr_o;
    logic [3:0]  mem_wr_byteen_o;
    logic [31:0] mem_wr_data_o;
    logic        mem_wr_ready_i;
    logic        busy_o;

    int errors = 0;
    int checks = 0;

    // {en, addr, byteen, data}
    logic [68:0] beat;
    assign beat = {mem_wr_en_o, mem_wr_addr_o, mem_wr_byteen_o, mem_wr_data_o};

    dram_wr #(.XLEN(32), .DEPTH(2)) dut (
        .clk_i           (clk_i),
        .rst_n_i         (rst_n_i),
        .req_valid_i     (req_valid_i),
        .req_ready_o     (req_ready_o),
        .dram_wr_sel_i   (dram_wr_sel_i),
        .dram_wr_addr_i  (dram_wr_addr_i),
        .dram_wr_data_i  (dram_wr_data_i),
        .mem_wr_en_o     (mem_wr_en_o),
        .mem_wr_addr_o   (mem_wr_addr_o),
        .mem_wr_byteen_o (mem_wr_byteen_o),
        .mem_wr_data_o   (mem_wr_data_o),
        .mem_wr_ready_i  (mem_wr_ready_i),
        .busy_o          (busy_o)
    );

    always #5 clk_i = ~clk_i;

    // Presents one request for one edge; caller sits just after a rising edge.
    task automatic enq(input logic [2:0] sel, input logic [31:0] addr, input logic [31:0] data);
        req_valid_i    = 1'b1;
        dram_wr_sel_i  = sel;
        dram_wr_addr_i = addr;
        dram_wr_data_i = data;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
    endtask

    task automatic test_reset;
        rst_n_i = 1'b0; req_valid_i = 1'b0; mem_wr_ready_i = 1'b1;
        dram_wr_sel_i = 3'd0; dram_wr_addr_i = '0; dram_wr_data_i = '0;
        #3;
        checks++;
        if (beat !== 69'd0) begin
            errors++; $display("FAIL reset_beat: got %h want 0", beat);
        end
        checks++;
        if ({req_ready_o, busy_o} !== 2'b10) begin
            errors++; $display("FAIL reset_ready_busy: got %b want 10", {req_ready_o, busy_o});
        end
        @(negedge clk_i); rst_n_i = 1'b1;
        @(posedge clk_i); #1;
    endtask

    task automatic test_aligned_word;
        mem_wr_ready_i = 1'b1;
        enq(SW, 32'h100, 32'hDEADBEEF);
        @(negedge clk_i);
        checks++;
        if (beat !== {1'b1, 32'h100, 4'b1111, 32'hDEADBEEF}) begin
            errors++; $display("FAIL sw_aligned_beat: got %h want %h", beat,
                               {1'b1, 32'h100, 4'b1111, 32'hDEADBEEF});
        end
        checks++;
        if (busy_o !== 1'b1) begin
            errors++; $display("FAIL sw_aligned_busy: got %b want 1", busy_o);
        end
        @(posedge clk_i); #1; @(negedge clk_i);
        checks++;
        if ({mem_wr_en_o, busy_o} !== 2'b00) begin
            errors++; $display("FAIL sw_aligned_done: got %b want 00", {mem_wr_en_o, busy_o});
        end
        @(posedge clk_i); #1;
    endtask

    task automatic test_byte_off3;
        enq(SB, 32'h103, 32'h123456A5);
        @(negedge clk_i);
        checks++;
        if (beat !== {1'b1, 32'h100, 4'b1000, 32'hA5000000}) begin
            errors++; $display("FAIL sb_off3_beat: got %h want %h", beat,
                               {1'b1, 32'h100, 4'b1000, 32'hA5000000});
        end
        @(posedge clk_i); #1; @(negedge clk_i);
        checks++;
        if (mem_wr_en_o !== 1'b0) begin
            errors++; $display("FAIL sb_off3_single: got en=%b want 0", mem_wr_en_o);
        end
        @(posedge clk_i); #1;
    endtask

    task automatic test_half_cross;
        enq(SH, 32'h203, 32'h00001234);
        @(negedge clk_i);
        checks++;
        if (beat !== {1'b1, 32'h200, 4'b1000, 32'h34000000}) begin
            errors++; $display("FAIL sh_cross_beat0: got %h want %h", beat,
                               {1'b1, 32'h200, 4'b1000, 32'h34000000});
        end
        @(posedge clk_i); #1; @(negedge clk_i);
        checks++;
        if (beat !== {1'b1, 32'h204, 4'b0001, 32'h00000012}) begin
            errors++; $display("FAIL sh_cross_beat1: got %h want %h", beat,
                               {1'b1, 32'h204, 4'b0001, 32'h00000012});
        end
        @(posedge clk_i); #1; @(negedge clk_i);
        checks++;
        if ({mem_wr_en_o, busy_o} !== 2'b00) begin
            errors++; $display("FAIL sh_cross_done: got %b want 00", {mem_wr_en_o, busy_o});
        end
        @(posedge clk_i); #1;
    endtask

    task automatic test_misaligned_stall;
        mem_wr_ready_i = 1'b0;
        enq(SW, 32'h102, 32'h11223344);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            checks++;
            if (beat !== {1'b1, 32'h100, 4'b1100, 32'h33440000}) begin
                errors++; $display("FAIL sw_stall_hold%0d: got %h want %h", i, beat,
                                   {1'b1, 32'h100, 4'b1100, 32'h33440000});
            end
            @(posedge clk_i); #1;
        end
        mem_wr_ready_i = 1'b1;
        @(posedge clk_i); #1; @(negedge clk_i);
        checks++;
        if (beat !== {1'b1, 32'h104, 4'b0011, 32'h00001122}) begin
            errors++; $display("FAIL sw_stall_beat1: got %h want %h", beat,
                               {1'b1, 32'h104, 4'b0011, 32'h00001122});
        end
        @(posedge clk_i); #1; @(negedge clk_i);
        checks++;
        if (busy_o !== 1'b0) begin
            errors++; $display("FAIL sw_stall_done: got busy=%b want 0", busy_o);
        end
        @(posedge clk_i); #1;
    endtask

    task automatic test_full;
        mem_wr_ready_i = 1'b0;
        enq(SW, 32'h300, 32'hAAAA0000);
        enq(SW, 32'h304, 32'hBBBB1111);
        req_valid_i = 1'b1; dram_wr_sel_i = SW;
        dram_wr_addr_i = 32'h308; dram_wr_data_i = 32'hCCCC2222;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_i);
            checks++;
            if (req_ready_o !== 1'b0) begin
                errors++; $display("FAIL full_ready%0d: got %b want 0", i, req_ready_o);
            end
            @(posedge clk_i); #1;
        end
        mem_wr_ready_i = 1'b1;
        @(negedge clk_i);
        checks++;
        if ({req_ready_o, beat} !== {1'b0, 1'b1, 32'h300, 4'b1111, 32'hAAAA0000}) begin
            errors++; $display("FAIL full_pop_cycle: got %h want %h", {req_ready_o, beat},
                               {1'b0, 1'b1, 32'h300, 4'b1111, 32'hAAAA0000});
        end
        @(posedge clk_i); #1; @(negedge clk_i);
        checks++;
        if ({req_ready_o, beat} !== {1'b1, 1'b1, 32'h304, 4'b1111, 32'hBBBB1111}) begin
            errors++; $display("FAIL full_second: got %h want %h", {req_ready_o, beat},
                               {1'b1, 1'b1, 32'h304, 4'b1111, 32'hBBBB1111});
        end
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        @(negedge clk_i);
        checks++;
        if (beat !== {1'b1, 32'h308, 4'b1111, 32'hCCCC2222}) begin
            errors++; $display("FAIL full_third: got %h want %h", beat,
                               {1'b1, 32'h308, 4'b1111, 32'hCCCC2222});
        end
        @(posedge clk_i); #1; @(negedge clk_i);
        checks++;
        if ({mem_wr_en_o, busy_o} !== 2'b00) begin
            errors++; $display("FAIL full_drained: got %b want 00", {mem_wr_en_o, busy_o});
        end
        @(posedge clk_i); #1;
    endtask

    task automatic test_invalid_sel;
        enq(3'd0, 32'h500, 32'h55555555);
        @(negedge clk_i);
        checks++;
        if ({req_ready_o, mem_wr_en_o, busy_o} !== 3'b100) begin
            errors++; $display("FAIL invalid_sel_dropped: got %b want 100",
                               {req_ready_o, mem_wr_en_o, busy_o});
        end
        @(posedge clk_i); #1;
    endtask

    task automatic test_reset_mid;
        mem_wr_ready_i = 1'b1;
        enq(SH, 32'h203, 32'h00001234);
        @(posedge clk_i); #1; @(negedge clk_i);
        checks++;
        if (beat !== {1'b1, 32'h204, 4'b0001, 32'h00000012}) begin
            errors++; $display("FAIL rst_mid_pre: got %h want %h", beat,
                               {1'b1, 32'h204, 4'b0001, 32'h00000012});
        end
        #1 rst_n_i = 1'b0;
        #1;
        checks++;
        if ({req_ready_o, busy_o, beat} !== {2'b10, 69'd0}) begin
            errors++; $display("FAIL rst_mid_async: got %h want %h",
                               {req_ready_o, busy_o, beat}, {2'b10, 69'd0});
        end
        @(negedge clk_i); rst_n_i = 1'b1;
        @(posedge clk_i); #1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            checks++;
            if ({mem_wr_en_o, busy_o} !== 2'b00) begin
                errors++; $display("FAIL rst_mid_quiet%0d: got %b want 00", i,
                                   {mem_wr_en_o, busy_o});
            end
            @(posedge clk_i); #1;
        end
        enq(SB, 32'h400, 32'h000000FF);
        @(negedge clk_i);
        checks++;
        if (beat !== {1'b1, 32'h400, 4'b0001, 32'h000000FF}) begin
            errors++; $display("FAIL rst_mid_new: got %h want %h", beat,
                               {1'b1, 32'h400, 4'b0001, 32'h000000FF});
        end
        @(posedge clk_i); #1;
    endtask

    task automatic test_wrap_addr;
        enq(SH, 32'hFFFFFFFF, 32'h0000BEEF);
        @(negedge clk_i);
        checks++;
        if (beat !== {1'b1, 32'hFFFFFFFC, 4'b1000, 32'hEF000000}) begin
            errors++; $display("FAIL wrap_beat0: got %h want %h", beat,
                               {1'b1, 32'hFFFFFFFC, 4'b1000, 32'hEF000000});
        end
        @(posedge clk_i); #1; @(negedge clk_i);
        checks++;
        if (beat !== {1'b1, 32'h00000000, 4'b0001, 32'h000000BE}) begin
            errors++; $display("FAIL wrap_beat1: got %h want %h", beat,
                               {1'b1, 32'h00000000, 4'b0001, 32'h000000BE});
        end
        @(posedge clk_i); #1;
    endtask

    initial begin
        test_reset();
        test_aligned_word();
        test_byte_off3();
        test_half_cross();
        test_misaligned_stall();
        test_full();
        test_invalid_sel();
        test_wrap_addr();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
